// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Request/response bundle for the I and D ports plus the
//               single-port word memory side of mem_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        i_rsp_err;

    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [1:0]  d_req_size;
    logic        d_req_unsigned;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;

    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        input  d_req_valid, d_req_addr, d_req_we, d_req_size, d_req_unsigned, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output mem_address, mem_write_data, mem_write_enable,
        input  mem_read_data
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        output d_req_valid, d_req_addr, d_req_we, d_req_size, d_req_unsigned, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  mem_address, mem_write_data, mem_write_enable,
        output mem_read_data
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one word memory between a fetch
//               port and a load/store port, with sub-word RMW stores.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int WORDS = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MERGE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [31:0] C_LIMIT = 32'(WORDS * 4);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_d;
    logic        r_owner_d;
    logic        r_half;
    logic [31:0] r_addr;
    logic [31:0] r_merge;
    logic [15:0] r_wdata;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_idle;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_accept;
    logic        w_we;
    logic        w_err;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // Gating with reset_n keeps every output low while reset is held.
    assign w_idle    = (r_state == S_IDLE) && reset_n;
    assign w_grant_i = w_idle && bus.i_req_valid && (!bus.d_req_valid || r_last_d);
    assign w_grant_d = w_idle && bus.d_req_valid && !(bus.i_req_valid && r_last_d);
    assign w_accept  = w_grant_i || w_grant_d;

    assign w_addr = w_grant_d ? bus.d_req_addr : bus.i_req_addr;
    assign w_size = w_grant_d ? bus.d_req_size : 2'b10;
    assign w_we   = w_grant_d && bus.d_req_we;
    assign w_err  = (w_addr >= C_LIMIT) || (w_size == 2'b11)
                 || ((w_size == 2'b01) && w_addr[0])
                 || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));

    assign w_half = w_addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

    always_comb begin
        case (w_addr[1:0])
            2'b00:   w_byte = bus.mem_read_data[7:0];
            2'b01:   w_byte = bus.mem_read_data[15:8];
            2'b10:   w_byte = bus.mem_read_data[23:16];
            default: w_byte = bus.mem_read_data[31:24];
        endcase
    end

    always_comb begin
        case (w_size)
            2'b00:   w_load = bus.d_req_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = bus.d_req_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = bus.mem_read_data;
        endcase
    end

    always_comb begin
        w_merged = r_merge;
        if (r_half) begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
        end else begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    always_comb begin
        w_state_next         = r_state;
        bus.i_req_ready      = 1'b0;
        bus.d_req_ready      = 1'b0;
        bus.i_rsp_valid      = 1'b0;
        bus.i_rsp_data       = 32'h0;
        bus.i_rsp_err        = 1'b0;
        bus.d_rsp_valid      = 1'b0;
        bus.d_rsp_data       = 32'h0;
        bus.d_rsp_err        = 1'b0;
        bus.mem_address      = 32'h0;
        bus.mem_write_data   = 32'h0;
        bus.mem_write_enable = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.i_req_ready = w_grant_i;
                bus.d_req_ready = w_grant_d;
                if (w_accept) begin
                    bus.mem_address = w_addr;
                    if (w_err) begin
                        w_state_next = S_RESP;
                    end else if (w_we && (w_size != 2'b10)) begin
                        w_state_next = S_MERGE;
                    end else begin
                        w_state_next = S_RESP;
                        if (w_we) begin
                            bus.mem_write_enable = 1'b1;
                            bus.mem_write_data   = bus.d_req_wdata;
                        end
                    end
                end
            end
            S_MERGE: begin
                bus.mem_address      = {r_addr[31:2], 2'b00};
                bus.mem_write_data   = w_merged;
                bus.mem_write_enable = 1'b1;
                w_state_next         = S_RESP;
            end
            S_RESP: begin
                if (r_owner_d) begin
                    bus.d_rsp_valid = 1'b1;
                    bus.d_rsp_data  = r_rsp_data;
                    bus.d_rsp_err   = r_rsp_err;
                end else begin
                    bus.i_rsp_valid = 1'b1;
                    bus.i_rsp_data  = r_rsp_data;
                    bus.i_rsp_err   = r_rsp_err;
                end
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b1;
            r_owner_d  <= 1'b0;
            r_half     <= 1'b0;
            r_addr     <= 32'h0;
            r_merge    <= 32'h0;
            r_wdata    <= 16'h0;
            r_rsp_data <= 32'h0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last_d   <= w_grant_d;
                r_owner_d  <= w_grant_d;
                r_half     <= w_size[0];
                r_addr     <= w_addr;
                r_merge    <= bus.mem_read_data;
                r_wdata    <= bus.d_req_wdata[15:0];
                r_rsp_err  <= w_err;
                r_rsp_data <= (w_err || w_we) ? 32'h0 : w_load;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed vector bench for mem_arbiter with a word memory model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        logic        exp_w;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
        int          exp_wk;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.WORDS(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'h0;
    int          wcnt = 0;
    int          drsp_cnt = 0;
    int          irsp_cnt = 0;
    int          total = 0;
    int          bad = 0;

    assign bus.mem_read_data = mem[bus.mem_address[7:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (bus.mem_write_enable) begin
            mem[bus.mem_address[7:2]] <= bus.mem_write_data;
            wcnt <= wcnt + 1;
        end
        if (bus.d_rsp_valid) drsp_cnt <= drsp_cnt + 1;
        if (bus.i_rsp_valid) irsp_cnt <= irsp_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_flags"}, 32'({bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid,
                                     bus.i_rsp_err, bus.d_rsp_err, bus.mem_write_enable}), 32'h0);
        check({name, "_buses"}, 32'(|{bus.mem_address, bus.mem_write_data, bus.i_rsp_data, bus.d_rsp_data}), 32'h0);
    endtask

    function automatic vec_t mk(input logic is_d, input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                                input logic exp_w, input logic [31:0] exp_waddr,
                                input logic [31:0] exp_wdata, input int exp_wk);
        vec_t v;
        v.is_d = is_d; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_w = exp_w; v.exp_waddr = exp_waddr; v.exp_wdata = exp_wdata; v.exp_wk = exp_wk;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.i_req_valid = 1'b0; bus.i_req_addr = 32'h0;
        bus.d_req_valid = 1'b0; bus.d_req_addr = 32'h0; bus.d_req_we = 1'b0;
        bus.d_req_size = 2'b10; bus.d_req_unsigned = 1'b0; bus.d_req_wdata = 32'h0;
    endtask

    // One isolated transaction: drive at a negedge, accept at the next posedge,
    // then watch up to four cycles for the write and the response.
    task automatic run_vec(input vec_t v, input string tag);
        logic        rdy, ordy, orsp, re;
        logic [31:0] rd, wa, wd;
        int          lat, nw, wk;
        rd = 32'h0; wa = 32'h0; wd = 32'h0; re = 1'b0; orsp = 1'b0;
        lat = -1; nw = 0; wk = -1;
        @(negedge clk);
        idle_inputs();
        if (v.is_d) begin
            bus.d_req_valid = 1'b1; bus.d_req_addr = v.addr; bus.d_req_we = v.we;
            bus.d_req_size = v.size; bus.d_req_unsigned = v.uns; bus.d_req_wdata = v.wdata;
        end else begin
            bus.i_req_valid = 1'b1; bus.i_req_addr = v.addr;
        end
        #1;
        rdy  = v.is_d ? bus.d_req_ready : bus.i_req_ready;
        ordy = v.is_d ? bus.i_req_ready : bus.d_req_ready;
        check({tag, "_ready"}, 32'({ordy, rdy}), 32'h1);
        if (bus.mem_write_enable) begin
            nw++; wa = bus.mem_address; wd = bus.mem_write_data; wk = 0;
        end
        @(negedge clk);
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (bus.mem_write_enable) begin
                nw++; wa = bus.mem_address; wd = bus.mem_write_data; wk = k;
            end
            if (v.is_d ? bus.i_rsp_valid : bus.d_rsp_valid) orsp = 1'b1;
            if (v.is_d ? bus.d_rsp_valid : bus.i_rsp_valid) begin
                lat = k;
                rd  = v.is_d ? bus.d_rsp_data : bus.i_rsp_data;
                re  = v.is_d ? bus.d_rsp_err : bus.i_rsp_err;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_data"}, rd, v.exp_data);
        check({tag, "_err"}, 32'(re), 32'(v.exp_err));
        check({tag, "_other_rsp"}, 32'(orsp), 32'h0);
        check({tag, "_nwrites"}, 32'(nw), 32'(v.exp_w));
        if (v.exp_w) begin
            check({tag, "_waddr"}, wa, v.exp_waddr);
            check({tag, "_wdata"}, wd, v.exp_wdata);
            check({tag, "_wcycle"}, 32'(wk), 32'(v.exp_wk));
        end
    endtask

    vec_t vecs[22];

    initial begin
        logic [3:0] seq;
        int         ng, both, w0, d0, i0;

        idle_inputs();
        pl_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pl_idx = 6'(i);
            case (i)
                1:       pl_data = 32'h11228344;
                2:       pl_data = 32'h12345678;
                3:       pl_data = 32'hDEADBEEF;
                63:      pl_data = 32'h80000000;
                default: pl_data = 32'h0;
            endcase
            @(negedge clk);
        end
        pl_en = 1'b0;

        // Outputs must be silent under reset even with requests pending.
        bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h8;
        bus.d_req_valid = 1'b1; bus.d_req_addr = 32'hC;
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;

        // Both ports requesting: grants must alternate starting with I.
        @(negedge clk);
        i0 = irsp_cnt; d0 = drsp_cnt;
        bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h8;
        bus.d_req_valid = 1'b1; bus.d_req_addr = 32'hC; bus.d_req_size = 2'b10;
        seq = 4'h0; ng = 0; both = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            #1;
            if (bus.i_req_ready && bus.d_req_ready) both++;
            if (bus.i_req_ready) begin
                seq = {seq[2:0], 1'b0}; ng++;
            end else if (bus.d_req_ready) begin
                seq = {seq[2:0], 1'b1}; ng++;
            end
            @(negedge clk);
        end
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rr_grants", 32'(ng), 32'd4);
        check("rr_order", 32'(seq), 32'h5);
        check("rr_both_ready", 32'(both), 32'h0);
        check("rr_irsp", 32'(irsp_cnt - i0), 32'd2);
        check("rr_drsp", 32'(drsp_cnt - d0), 32'd2);

        vecs[0]  = mk(0, 0, 2'b10, 0, 32'h8,   32'h0,        32'h12345678, 0, 1, 0, 32'h0, 32'h0, 0);
        vecs[1]  = mk(1, 0, 2'b01, 0, 32'h4,   32'h0,        32'hFFFF8344, 0, 1, 0, 32'h0, 32'h0, 0);
        vecs[2]  = mk(1, 0, 2'b00, 1, 32'h5,   32'h0,        32'h00000083, 0, 1, 0, 32'h0, 32'h0, 0);
        vecs[3]  = mk(1, 0, 2'b00, 0, 32'h7,   32'h0,        32'h00000011, 0, 1, 0, 32'h0, 32'h0, 0);
        vecs[4]  = mk(1, 0, 2'b00, 0, 32'h5,   32'h0,        32'hFFFFFF83, 0, 1, 0, 32'h0, 32'h0, 0);
        vecs[5]  = mk(1, 0, 2'b01, 1, 32'h6,   32'h0,        32'h00001122, 0, 1, 0, 32'h0, 32'h0, 0);
        vecs[6]  = mk(1, 0, 2'b10, 0, 32'hC,   32'h0,        32'hDEADBEEF, 0, 1, 0, 32'h0, 32'h0, 0);
        vecs[7]  = mk(0, 0, 2'b10, 0, 32'h6,   32'h0,        32'h0,        1, 1, 0, 32'h0, 32'h0, 0);
        vecs[8]  = mk(0, 0, 2'b10, 0, 32'h100, 32'h0,        32'h0,        1, 1, 0, 32'h0, 32'h0, 0);
        vecs[9]  = mk(1, 1, 2'b10, 0, 32'h6,   32'h55555555, 32'h0,        1, 1, 0, 32'h0, 32'h0, 0);
        vecs[10] = mk(1, 0, 2'b01, 0, 32'h3,   32'h0,        32'h0,        1, 1, 0, 32'h0, 32'h0, 0);
        vecs[11] = mk(1, 1, 2'b11, 0, 32'h4,   32'h12345678, 32'h0,        1, 1, 0, 32'h0, 32'h0, 0);
        vecs[12] = mk(1, 0, 2'b10, 0, 32'h100, 32'h0,        32'h0,        1, 1, 0, 32'h0, 32'h0, 0);
        vecs[13] = mk(1, 1, 2'b01, 0, 32'h1,   32'h0000BEEF, 32'h0,        1, 1, 0, 32'h0, 32'h0, 0);
        vecs[14] = mk(1, 1, 2'b10, 0, 32'h10,  32'hA5A5A5A5, 32'h0,        0, 1, 1, 32'h10, 32'hA5A5A5A5, 0);
        vecs[15] = mk(1, 1, 2'b01, 0, 32'hE,   32'h1234CAFE, 32'h0,        0, 2, 1, 32'hC,  32'hCAFEBEEF, 1);
        vecs[16] = mk(1, 1, 2'b00, 0, 32'h5,   32'hFFFFFFAB, 32'h0,        0, 2, 1, 32'h4,  32'h1122AB44, 1);
        vecs[17] = mk(1, 1, 2'b00, 0, 32'hF,   32'h00000077, 32'h0,        0, 2, 1, 32'hC,  32'h77FEBEEF, 1);
        vecs[18] = mk(1, 0, 2'b10, 0, 32'hC,   32'h0,        32'h77FEBEEF, 0, 1, 0, 32'h0, 32'h0, 0);
        vecs[19] = mk(1, 0, 2'b01, 0, 32'h4,   32'h0,        32'hFFFFAB44, 0, 1, 0, 32'h0, 32'h0, 0);
        vecs[20] = mk(1, 0, 2'b10, 0, 32'hFC,  32'h0,        32'h80000000, 0, 1, 0, 32'h0, 32'h0, 0);
        vecs[21] = mk(1, 0, 2'b00, 0, 32'hFF,  32'h0,        32'hFFFFFF80, 0, 1, 0, 32'h0, 32'h0, 0);

        for (int i = 0; i < 22; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end
        check("mem4_word", mem[4], 32'hA5A5A5A5);

        // Reset landing in MERGE must cancel the pending write and response.
        @(negedge clk);
        w0 = wcnt; d0 = drsp_cnt;
        bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h8; bus.d_req_we = 1'b1;
        bus.d_req_size = 2'b01; bus.d_req_wdata = 32'h00005555;
        #1;
        check("rstm_ready", 32'(bus.d_req_ready), 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rstm_in_merge", 32'(bus.mem_write_enable), 32'h1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("rstm");
        repeat (3) @(negedge clk);
        check("rstm_nwrite", 32'(wcnt - w0), 32'h0);
        check("rstm_nrsp", 32'(drsp_cnt - d0), 32'h0);
        check("rstm_mem2", mem[2], 32'h12345678);
        reset_n = 1'b1;
        run_vec(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port word memory between the instruction-fetch port (I, read-only) and the load/store port (D).
- Arbitrates round-robin when both request, with one transaction in flight at a time.
- Implements byte and halfword stores by read-modify-write, because the memory writes aligned whole words only.
- Performs load extraction and sign/zero extension, and flags misaligned, out-of-range and bad-size accesses as errors.

Parameters:
- WORDS, 64, memory depth in 32-bit words; valid byte addresses are 0 .. WORDS*4-1.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset; one clock; asynchronous, active-low
- i_req_valid  input  1  fetch request
- i_req_ready  output  1  fetch request accepted this cycle when high with valid
- i_req_addr  input  32  fetch byte address
- i_rsp_valid  output  1  fetch response, one-cycle pulse
- i_rsp_data  output  32  fetched word
- i_rsp_err  output  1  fetch error (misaligned or out of range)
- d_req_valid  input  1  data request
- d_req_ready  output  1  data request accepted this cycle when high with valid
- d_req_addr  input  32  data byte address
- d_req_we  input  1  1 = store, 0 = load
- d_req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- d_req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- d_req_wdata  input  32  store data, right-justified
- d_rsp_valid  output  1  data response, one-cycle pulse
- d_rsp_data  output  32  extended load data; 0 for stores and errors
- d_rsp_err  output  1  data error
- mem_address  output  32  to memory address
- mem_write_data  output  32  to memory write data
- mem_write_enable  output  1  to memory write enable
- mem_read_data  input  32  from memory; combinational read of mem_address

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE, last_grant = D (so I wins the first tie).
  - All outputs 0: ready, rsp_valid, rsp_data, rsp_err, mem_write_enable, mem_address, mem_write_data.
  - Reset mid-transaction abandons it: no response is issued, and a pending RMW write is never performed.
- States: IDLE, MERGE, RESP.
- IDLE:
  - i_req_ready / d_req_ready are high only in IDLE, and only for the granted port. Grant is combinational from the valids.
  - Sole requester wins. If both request, the port not in last_grant wins; last_grant updates on accept.
  - mem_address = granted address (0 when none).
  - Accept cycle: evaluate error. Error if:
    - address >= WORDS*4; or
    - size 11; or
    - half with addr[0]=1; or
    - word with addr[1:0]!=0.
    - I port is always word-size.
  - Error → no memory write; go to RESP with err=1, data=0.
  - Load or fetch: capture mem_read_data and extract byte/half using addr[1:0]. Byte lane = addr[1:0]; half lane = addr[1]. Extend per d_req_unsigned; fetch returns the full word. Go to RESP.
  - Word store: mem_write_enable=1 and mem_write_data=wdata in the accept cycle; go to RESP.
  - Byte/half store: capture the old word mem_read_data into merge_q, along with lane, size and wdata; go to MERGE. No write in the accept cycle.
- MERGE (1 cycle):
  - mem_address = captured address with bits [1:0] forced to 00.
  - mem_write_data = merge_q with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - mem_write_enable = 1. Go to RESP.
- RESP (1 cycle):
  - Pulse rsp_valid on the owning port with registered data/err. There is no backpressure; the requester must take it.
  - Then return to IDLE. New requests are accepted on the following cycle.
- Latency from accept to rsp_valid:
  - load, fetch, word store, error: 1 cycle.
  - sub-word store: 2 cycles.
- mem_write_enable is never asserted outside the word-store accept cycle or MERGE.
- The non-owning port's rsp_valid stays 0 throughout.
- Requests held valid while not ready are untouched; addr/data must stay stable until accepted.

Test Plan:
- Reset, then I fetch addr 0x8 with mem[2]=0x12345678 → i_req_ready in the same cycle; i_rsp_valid next cycle with 0x12345678, err=0.
- I and D both valid for 4 consecutive transactions → grants alternate I, D, I, D; first grant goes to I.
- D byte store 0xAB at addr 0x5 with mem[1]=0x11223344 → mem_write_enable only in MERGE, writing 0x1122AB44 to address 0x4; d_rsp_valid 2 cycles after accept.
- D loads from mem[1]=0x11228344:
  - signed half at 0x4 → 0xFFFF8344;
  - unsigned byte at 0x5 → 0x00000083;
  - signed byte at 0x7 → 0x00000011.
- Error cases, each → d_rsp_err=1, data 0, mem_write_enable never high:
  - word store at 0x6;
  - half load at 0x3;
  - size 11;
  - address 0x100 with WORDS=64.
- Assert reset_n in the MERGE cycle of a half store → no memory write, no d_rsp_valid; outputs return to 0 immediately; the next request is served normally after release.
